branch_resolve_unit: RTL and testbench

- Resolve-side partner of the IF/ID branch predictor.
- Takes each branch outcome computed in ID and compares it with the prediction carried down from IF. Drives the mispredict flush and redirect PC.
- Queues one training record per resolved branch in a small FIFO. The FIFO drains to the BHT/BTB write port over a valid/ready handshake, so table writes never stall the pipeline.

---
 rtl/branch_resolve_unit.sv | 178 +++++++++++++++++
 tb/tb_branch_resolve_unit.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : branch_resolve_unit
// Description : Resolve-side partner of the IF/ID branch predictor. Compares
//               the branch outcome computed in ID with the prediction carried
//               down from IF, raises the mispredict flush with the redirect
//               PC, and queues one training record per resolved branch in a
//               small FIFO that drains to the BHT/BTB write port over a
//               valid/ready handshake.
// Ports       : clk, rst (async, active-low)
//               ID side    : data_stall, br_valid_ID, taken_ID, target_ID,
//                            PC_ID, pred_jmp_ID, hit_ID, pred_target_ID
//               Flush      : fail, redirect_PC (combinational)
//               Update FIFO: upd_valid/upd_ready handshake, upd_PC,
//                            upd_taken, upd_target, upd_alloc, upd_drop,
//                            fifo_level
//               Statistics : stat_br, stat_miss, stat_drop
// Options     : BRU_STATS_EN - when defined, stat_* are live 32-bit
//               counters; otherwise they are tied to zero.
// Revision    : 1.0 - initial release
// ============================================================================
module branch_resolve_unit #(
  parameter int FIFO_DEPTH = 4,
  parameter int FIFO_AW    = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 data_stall,
  input  logic                 br_valid_ID,
  input  logic                 taken_ID,
  input  logic [31:0]          target_ID,
  input  logic [31:0]          PC_ID,
  input  logic                 pred_jmp_ID,
  input  logic                 hit_ID,
  input  logic [31:0]          pred_target_ID,
  output logic                 fail,
  output logic [31:0]          redirect_PC,
  output logic                 upd_valid,
  input  logic                 upd_ready,
  output logic [31:0]          upd_PC,
  output logic                 upd_taken,
  output logic [31:0]          upd_target,
  output logic                 upd_alloc,
  output logic                 upd_drop,
  output logic [FIFO_AW:0]     fifo_level,
  output logic [31:0]          stat_br,
  output logic [31:0]          stat_miss,
  output logic [31:0]          stat_drop
);

  localparam logic [FIFO_AW:0]   C_DEPTH   = (FIFO_AW+1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW-1:0] C_PTR_ONE = FIFO_AW'(1);

  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        alloc;
  } entry_t;

  // --------------------------------------------------------------------------
  // Resolve / mispredict detection
  // --------------------------------------------------------------------------
  logic   res;
  logic   act_taken;
  logic   dir_miss;
  logic   tgt_miss;
  entry_t new_entry;

  always_comb begin
    res       = br_valid_ID & ~data_stall;
    act_taken = br_valid_ID & taken_ID;
    dir_miss  = pred_jmp_ID ^ act_taken;
    // A BTB miss on a predicted-taken branch means IF had no real target.
    tgt_miss  = act_taken & pred_jmp_ID & (~hit_ID | (pred_target_ID != target_ID));
    fail      = ~data_stall & (dir_miss | tgt_miss);
    redirect_PC = 32'd0;
    if (fail) begin
      redirect_PC = act_taken ? target_ID : (PC_ID + 32'd4);
    end
    new_entry.pc     = PC_ID;
    new_entry.taken  = taken_ID;
    new_entry.target = target_ID;
    new_entry.alloc  = taken_ID & (~hit_ID | tgt_miss);
  end

  // --------------------------------------------------------------------------
  // Update FIFO
  // --------------------------------------------------------------------------
  entry_t               mem_q [FIFO_DEPTH];
  logic [FIFO_AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [FIFO_AW:0]     level_q, level_d;
  logic                 drop_q, drop_d;
  logic                 full;
  logic                 pop;
  logic                 push_ok;

  always_comb begin
    full    = (level_q == C_DEPTH);
    pop     = upd_valid & upd_ready;
    // When full, a same-cycle pop frees the slot the push lands in.
    push_ok = res & (~full | pop);
    drop_d  = res & full & ~pop;
    wr_ptr_d = push_ok ? (wr_ptr_q + C_PTR_ONE) : wr_ptr_q;
    rd_ptr_d = pop     ? (rd_ptr_q + C_PTR_ONE) : rd_ptr_q;
    level_d  = level_q;
    if (push_ok && !pop) begin
      level_d = level_q + (FIFO_AW+1)'(1);
    end else if (!push_ok && pop) begin
      level_d = level_q - (FIFO_AW+1)'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
      drop_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
      drop_q   <= drop_d;
    end
  end

  // Storage needs no reset: an entry is only exposed once occupancy covers it.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem_q[wr_ptr_q] <= new_entry;
    end
  end

  entry_t head;

  always_comb begin
    upd_valid  = (level_q != '0);
    // Zero the head fields when empty so reset/idle values are clean.
    head       = upd_valid ? mem_q[rd_ptr_q] : '0;
    upd_PC     = head.pc;
    upd_taken  = head.taken;
    upd_target = head.target;
    upd_alloc  = head.alloc;
    upd_drop   = drop_q;
    fifo_level = level_q;
  end

  // --------------------------------------------------------------------------
  // Optional statistics
  // --------------------------------------------------------------------------
`ifdef BRU_STATS_EN
  logic [31:0] stat_br_q, stat_miss_q, stat_drop_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      stat_br_q   <= '0;
      stat_miss_q <= '0;
      stat_drop_q <= '0;
    end else begin
      if (res)    stat_br_q   <= stat_br_q + 32'd1;
      if (fail)   stat_miss_q <= stat_miss_q + 32'd1;
      if (drop_d) stat_drop_q <= stat_drop_q + 32'd1;
    end
  end

  assign stat_br   = stat_br_q;
  assign stat_miss = stat_miss_q;
  assign stat_drop = stat_drop_q;
`else
  assign stat_br   = 32'd0;
  assign stat_miss = 32'd0;
  assign stat_drop = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_branch_resolve_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_branch_resolve_unit
// Description : Self-checking bench for branch_resolve_unit. A behavioural
//               queue model is compared against the DUT on every falling
//               edge; directed vectors add literal expectations.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_branch_resolve_unit;

  localparam int DEPTH = 4;
  localparam int AW    = 2;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        data_stall = 1'b0;
  logic        br_valid_ID = 1'b0;
  logic        taken_ID = 1'b0;
  logic [31:0] target_ID = '0;
  logic [31:0] PC_ID = '0;
  logic        pred_jmp_ID = 1'b0;
  logic        hit_ID = 1'b0;
  logic [31:0] pred_target_ID = '0;
  logic        upd_ready = 1'b0;
  logic        fail;
  logic [31:0] redirect_PC;
  logic        upd_valid;
  logic [31:0] upd_PC;
  logic        upd_taken;
  logic [31:0] upd_target;
  logic        upd_alloc;
  logic        upd_drop;
  logic [AW:0] fifo_level;
  logic [31:0] stat_br, stat_miss, stat_drop;

  int checks = 0;
  int failures = 0;

  branch_resolve_unit #(.FIFO_DEPTH(DEPTH), .FIFO_AW(AW)) dut (
    .clk(clk), .rst(rst), .data_stall(data_stall), .br_valid_ID(br_valid_ID),
    .taken_ID(taken_ID), .target_ID(target_ID), .PC_ID(PC_ID),
    .pred_jmp_ID(pred_jmp_ID), .hit_ID(hit_ID), .pred_target_ID(pred_target_ID),
    .fail(fail), .redirect_PC(redirect_PC), .upd_valid(upd_valid),
    .upd_ready(upd_ready), .upd_PC(upd_PC), .upd_taken(upd_taken),
    .upd_target(upd_target), .upd_alloc(upd_alloc), .upd_drop(upd_drop),
    .fifo_level(fifo_level), .stat_br(stat_br), .stat_miss(stat_miss),
    .stat_drop(stat_drop)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic [31:0] pc;
    logic        taken;
    logic [31:0] target;
    logic        alloc;
  } rec_t;

  rec_t        mq[$];
  logic        m_drop = 1'b0;
  logic [31:0] m_br = '0, m_miss = '0, m_drop_cnt = '0;

  // Mispredict: the next PC IF chose differs from the real one.
  function automatic logic m_fail();
    logic act, ok;
    act = br_valid_ID & taken_ID;
    ok  = (pred_jmp_ID == act) && (!act || (hit_ID && pred_target_ID == target_ID));
    return !data_stall && !ok;
  endfunction

  function automatic logic [31:0] m_redirect();
    if (!m_fail()) return 32'd0;
    if (br_valid_ID && taken_ID) return target_ID;
    return PC_ID + 32'd4;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      mq.delete();
      m_drop = 1'b0;
      m_br = '0; m_miss = '0; m_drop_cnt = '0;
    end else begin
      logic push, pop, was_full;
      rec_t r;
      push     = br_valid_ID && !data_stall;
      pop      = (mq.size() != 0) && upd_ready;
      was_full = (mq.size() == DEPTH);
      r.pc     = PC_ID;
      r.taken  = taken_ID;
      r.target = target_ID;
      r.alloc  = taken_ID && (!hit_ID || (pred_jmp_ID && pred_target_ID != target_ID));
      if (m_fail()) m_miss = m_miss + 1;
      if (push) m_br = m_br + 1;
      if (pop) void'(mq.pop_front());
      m_drop = 1'b0;
      if (push) begin
        if (was_full && !pop) begin
          m_drop = 1'b1;
          m_drop_cnt = m_drop_cnt + 1;
        end else begin
          mq.push_back(r);
        end
      end
    end
  end

  always @(negedge clk) begin
    chk("fail", {31'd0, fail}, {31'd0, m_fail()});
    chk("redirect_PC", redirect_PC, m_redirect());
    chk("upd_valid", {31'd0, upd_valid}, {31'd0, mq.size() != 0});
    chk("fifo_level", {29'd0, fifo_level}, 32'(mq.size()));
    chk("upd_drop", {31'd0, upd_drop}, {31'd0, m_drop});
    if (mq.size() != 0) begin
      chk("upd_PC", upd_PC, mq[0].pc);
      chk("upd_taken", {31'd0, upd_taken}, {31'd0, mq[0].taken});
      chk("upd_target", upd_target, mq[0].target);
      chk("upd_alloc", {31'd0, upd_alloc}, {31'd0, mq[0].alloc});
    end
`ifdef BRU_STATS_EN
    chk("stat_br", stat_br, m_br);
    chk("stat_miss", stat_miss, m_miss);
    chk("stat_drop", stat_drop, m_drop_cnt);
`else
    chk("stat_br", stat_br, 32'd0);
    chk("stat_miss", stat_miss, 32'd0);
    chk("stat_drop", stat_drop, 32'd0);
`endif
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic bv, input logic tk, input logic [31:0] pc,
                       input logic [31:0] tgt, input logic pj, input logic hit,
                       input logic [31:0] ptgt);
    br_valid_ID = bv; taken_ID = tk; PC_ID = pc; target_ID = tgt;
    pred_jmp_ID = pj; hit_ID = hit; pred_target_ID = ptgt;
  endtask

  task automatic idle();
    drive(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 32'h0);
    data_stall = 1'b0;
  endtask

  task automatic drain();
    idle();
    upd_ready = 1'b1;
    for (int i = 0; i < 8; i++) step();
    upd_ready = 1'b0;
  endtask

  initial begin
    #2;
    chk("rst upd_valid", {31'd0, upd_valid}, 32'd0);
    chk("rst fifo_level", {29'd0, fifo_level}, 32'd0);
    chk("rst upd_drop", {31'd0, upd_drop}, 32'd0);
    chk("rst upd_PC", upd_PC, 32'd0);
    step();
    rst = 1'b1;
    step();

    // Correct prediction
    drive(1'b1, 1'b1, 32'h100, 32'h200, 1'b1, 1'b1, 32'h200);
    #1 chk("ok fail", {31'd0, fail}, 32'd0);
    step();
    idle();
    chk("ok upd_valid", {31'd0, upd_valid}, 32'd1);
    chk("ok upd_PC", upd_PC, 32'h100);
    chk("ok upd_taken", {31'd0, upd_taken}, 32'd1);
    chk("ok upd_alloc", {31'd0, upd_alloc}, 32'd0);
    drain();

    // Direction miss, not taken
    drive(1'b1, 1'b0, 32'h40, 32'h80, 1'b1, 1'b1, 32'h80);
    #1 chk("dir fail", {31'd0, fail}, 32'd1);
    chk("dir redirect", redirect_PC, 32'h44);
    step();
    idle();
    chk("dir upd_taken", {31'd0, upd_taken}, 32'd0);
    chk("dir upd_alloc", {31'd0, upd_alloc}, 32'd0);
    drain();

    // Target miss
    drive(1'b1, 1'b1, 32'h60, 32'h380, 1'b1, 1'b1, 32'h300);
    #1 chk("tgt fail", {31'd0, fail}, 32'd1);
    chk("tgt redirect", redirect_PC, 32'h380);
    step();
    idle();
    chk("tgt upd_alloc", {31'd0, upd_alloc}, 32'd1);
    chk("tgt upd_target", upd_target, 32'h380);
    drain();

    // BTB miss on a taken branch predicted not-taken allocates
    drive(1'b1, 1'b1, 32'h70, 32'h900, 1'b0, 1'b0, 32'h0);
    #1 chk("alloc redirect", redirect_PC, 32'h900);
    step();
    idle();
    chk("alloc upd_alloc", {31'd0, upd_alloc}, 32'd1);
    drain();

    // Backpressure and overflow
    upd_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b0, 32'h1000 + 32'(i * 4), 32'h0, 1'b0, 1'b0, 32'h0);
      step();
      chk("ovf upd_drop", {31'd0, upd_drop}, (i == 4) ? 32'd1 : 32'd0);
    end
    chk("ovf level", {29'd0, fifo_level}, 32'd4);
    upd_ready = 1'b1;
    drive(1'b1, 1'b0, 32'h2000, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    chk("ovf pushpop drop", {31'd0, upd_drop}, 32'd0);
    chk("ovf pushpop level", {29'd0, fifo_level}, 32'd4);
    idle();
    upd_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] exp_pc;
      exp_pc = (i == 3) ? 32'h2000 : 32'h1004 + 32'(i * 4);
      #1 chk("drain order", upd_PC, exp_pc);
      step();
    end
    chk("drain empty", {31'd0, upd_valid}, 32'd0);
    upd_ready = 1'b0;

    // Stall: nothing evaluated
    data_stall = 1'b1;
    drive(1'b1, 1'b1, 32'h300, 32'h400, 1'b0, 1'b0, 32'h0);
    #1 chk("stall fail", {31'd0, fail}, 32'd0);
    step();
    chk("stall no push", {29'd0, fifo_level}, 32'd0);
    idle();

    // Non-branch predicted taken, and PC wrap
    drive(1'b0, 1'b0, 32'h500, 32'h0, 1'b1, 1'b1, 32'h700);
    #1 chk("nonbr redirect", redirect_PC, 32'h504);
    drive(1'b1, 1'b0, 32'hFFFF_FFFC, 32'h0, 1'b1, 1'b1, 32'h10);
    #1 chk("wrap fail", {31'd0, fail}, 32'd1);
    chk("wrap redirect", redirect_PC, 32'h0);
    step();
    idle();
    drain();

    // Reset mid-drain with level 3
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'h3000 + 32'(i * 4), 32'h3100, 1'b1, 1'b1, 32'h3100);
      step();
    end
    idle();
    upd_ready = 1'b1;
    step();
    chk("pre-rst level", {29'd0, fifo_level}, 32'd3);
    #1 rst = 1'b0;
    #1;
    chk("rst upd_valid mid", {31'd0, upd_valid}, 32'd0);
    chk("rst level mid", {29'd0, fifo_level}, 32'd0);
    chk("rst stat_br", stat_br, 32'd0);
    chk("rst stat_miss", stat_miss, 32'd0);
    chk("rst stat_drop", stat_drop, 32'd0);
    drive(1'b1, 1'b0, 32'h4000, 32'h0, 1'b0, 1'b0, 32'h0);
    step();
    chk("rst no push", {29'd0, fifo_level}, 32'd0);
    idle();
    rst = 1'b1;
    step();
    step();
    upd_ready = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
